// File: rtl/ram_arbiter.sv
// Two-client arbiter in front of a single-port RAM with a registered read.
// Client 0 has priority, client 1 is protected by a starve limit, and either client may lock.
module ram_arbiter #(
   parameter int unsigned WORD_SIZE    = 20,
   parameter int unsigned ADDR_SIZE    = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 c0_req_i,
   input  logic [ADDR_SIZE-1:0] c0_addr_i,
   input  logic [WORD_SIZE-1:0] c0_value_i,
   input  logic                 c0_write_i,
   input  logic                 c0_lock_i,
   output logic                 c0_gnt_o,
   output logic                 c0_rvalid_o,
   input  logic                 c1_req_i,
   input  logic [ADDR_SIZE-1:0] c1_addr_i,
   input  logic [WORD_SIZE-1:0] c1_value_i,
   input  logic                 c1_write_i,
   input  logic                 c1_lock_i,
   output logic                 c1_gnt_o,
   output logic                 c1_rvalid_o,
   output logic [WORD_SIZE-1:0] rdata_o,
   output logic [ADDR_SIZE-1:0] ram_addr_o,
   output logic [WORD_SIZE-1:0] ram_value_o,
   output logic                 ram_write_o,
   input  logic [WORD_SIZE-1:0] ram_value_i
);

   typedef enum logic [1:0] {StIdle, StLock0, StLock1} state_e;

   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   state_e     state_q, state_d;
   logic [3:0] starve_q, starve_d;
   logic       rvalid0_q, rvalid1_q;
   logic       gnt0, gnt1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         starve_q  <= '0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         starve_q  <= starve_d;
         rvalid0_q <= gnt0 & ~c0_write_i;
         rvalid1_q <= gnt1 & ~c1_write_i;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (gnt0 && c0_lock_i) begin
               state_d = StLock0;
            end else if (gnt1 && c1_lock_i) begin
               state_d = StLock1;
            end
         end
         // Dropping the request also releases the lock, with no grant that cycle.
         StLock0: if (!gnt0 || !c0_lock_i) state_d = StIdle;
         StLock1: if (!gnt1 || !c1_lock_i) state_d = StIdle;
         default: state_d = StIdle;
      endcase

      if (c1_req_i && !gnt1) begin
         starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 4'd1;
      end else begin
         starve_d = '0;
      end
   end

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      case (state_q)
         StIdle: begin
            if (c0_req_i && c1_req_i) begin
               if (starve_q == StarveMax) gnt1 = 1'b1;
               else                       gnt0 = 1'b1;
            end else begin
               gnt0 = c0_req_i;
               gnt1 = c1_req_i;
            end
         end
         StLock0: gnt0 = c0_req_i;
         StLock1: gnt1 = c1_req_i;
         default: ;
      endcase

      c0_gnt_o    = gnt0;
      c1_gnt_o    = gnt1;
      c0_rvalid_o = rvalid0_q;
      c1_rvalid_o = rvalid1_q;
      ram_addr_o  = gnt1 ? c1_addr_i : c0_addr_i;
      ram_value_o = gnt1 ? c1_value_i : c0_value_i;
      ram_write_o = (gnt0 & c0_write_i) | (gnt1 & c1_write_i);
      rdata_o     = ram_value_i;
   end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 20, meaning data word width.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 16, meaning address width.
REQ-003 The block SHALL have parameter STARVE_LIMIT, default 4, meaning the maximum number of consecutive cycles client 1 may be denied before it wins (range 1..15).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have client ports c0_req_i, c1_req_i, input, 1 bit each: access request.
REQ-007 The block SHALL have client ports c0_addr_i, c1_addr_i, input, ADDR_SIZE bits each: access address.
REQ-008 The block SHALL have client ports c0_value_i, c1_value_i, input, WORD_SIZE bits each: write data.
REQ-009 The block SHALL have client ports c0_write_i, c1_write_i, input, 1 bit each: 1 = write, 0 = read.
REQ-010 The block SHALL have client ports c0_lock_i, c1_lock_i, input, 1 bit each: retain ownership after this access.
REQ-011 The block SHALL have client ports c0_gnt_o, c1_gnt_o, output, 1 bit each: access accepted this cycle (combinational).
REQ-012 The block SHALL have client ports c0_rvalid_o, c1_rvalid_o, output, 1 bit each: read data valid this cycle (registered).
REQ-013 The block SHALL have port rdata_o, output, WORD_SIZE bits: shared read data, driven directly from ram_value_i.
REQ-014 The block SHALL have ports ram_addr_o, ram_value_o, ram_write_o, output, ADDR_SIZE / WORD_SIZE / 1 bits: drive the single-port RAM (registered read, 1-cycle latency).
REQ-015 The block SHALL have port ram_value_i, input, WORD_SIZE bits: RAM read data.

Function
REQ-016 At most one of c0_gnt_o/c1_gnt_o SHALL be 1 in any cycle; a grant SHALL be given only to a requesting client.
REQ-017 The granted client's addr, value and write SHALL be muxed combinationally onto ram_addr_o/ram_value_o/ram_write_o in the same cycle.
REQ-018 With no grant, ram_write_o SHALL be 0 and ram_addr_o SHALL equal c0_addr_i.
REQ-019 State machine states SHALL be IDLE, LOCK0 and LOCK1.
REQ-020 In IDLE, client 0 SHALL win when both request, unless the starve count equals STARVE_LIMIT, in which case client 1 SHALL win.
REQ-021 A granted access with lock_i=1 SHALL move the state to LOCKn for the granted client n.
REQ-022 In LOCKn only client n SHALL be granted, regardless of the other client or the starve count.
REQ-023 LOCKn SHALL return to IDLE after a granted access of client n with lock_i=0, or in any cycle client n does not request (no grant that cycle).
REQ-024 The starve counter SHALL increment, saturating at STARVE_LIMIT, in each cycle c1_req_i=1 and c1_gnt_o=0.
REQ-025 The starve counter SHALL clear to 0 in any cycle c1_gnt_o=1 or c1_req_i=0.
REQ-026 cn_rvalid_o SHALL be 1 exactly one cycle after a cycle in which cn_gnt_o=1 and cn_write_i=0; granted writes SHALL produce no rvalid.
REQ-027 rdata_o SHALL be valid only while some rvalid is 1; back-to-back granted reads SHALL yield rvalid on consecutive cycles.
REQ-028 A client whose request is not granted SHALL hold its inputs stable until granted; the block SHALL NOT queue requests.

Reset
REQ-029 While reset_n=0 the state SHALL be IDLE, the starve counter 0, and c0_rvalid_o=c1_rvalid_o=0, asynchronously.
REQ-030 Grants SHALL follow REQ-020 rules from the first clock edge after reset release; a reset asserted mid-lock SHALL drop the lock, and no rvalid SHALL issue for an access granted in the cycle reset asserts.

Verification
REQ-031 The bench SHALL check: c0 write addr 0x0010 value 0x12345, then c0 read 0x0010 -> c0_gnt_o=1 both cycles; c0_rvalid_o=1 one cycle after the read with rdata_o=0x12345; c1_rvalid_o=0 throughout.
REQ-032 The bench SHALL check: both clients read continuously, STARVE_LIMIT=4 -> c0 granted 4 cycles, c1 granted the 5th, pattern repeats.
REQ-033 The bench SHALL check: c1 asserts lock for a 3-access read-modify-write while c0 requests -> c1 granted 3 consecutive cycles; c0 granted the cycle after c1's lock_i=0 access.
REQ-034 The bench SHALL check: c0 in LOCK0 drops c0_req_i -> same cycle c1 not granted; the next cycle c1 is granted (state IDLE).
REQ-035 The bench SHALL check: reset_n pulsed low while in LOCK1 with a pending read -> rvalids 0 immediately; after release, simultaneous requests grant c0.
REQ-036 The bench SHALL check: no requests -> ram_write_o=0 and both grants 0 every cycle.
